// File: rtl/timer_seq_ctrl_if.sv
// APB bus between the timer sequencer (master) and the timer register block (slave).
interface timer_seq_ctrl_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_seq_ctrl.sv
// APB-master sequencer: loads and enables the timer, polls its status flag, clears it and
// reports each event, optionally re-arming with the configuration captured at start.
module timer_seq_ctrl #(
    parameter logic [7:0] ADDR_TDR = 8'h00,
    parameter logic [7:0] ADDR_TCR = 8'h01,
    parameter logic [7:0] ADDR_TSR = 8'h02,
    parameter int         POLL_GAP = 4,
    parameter int         CNT_W    = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       cfg_tdr,
    input  logic             cfg_updown,
    input  logic [1:0]       cfg_cks,
    input  logic             cfg_periodic,
    output logic             busy,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             err,
    timer_seq_ctrl_if.master apb
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_TDR, S_WR_LOAD, S_WR_EN, S_GAP,
        S_RD_TSR, S_WR_CLR, S_EVT, S_WR_DIS, S_ERR
    } state_t;

    // A transfer state walks GAP (psel low) -> SETUP -> ACCESS.
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

    localparam logic [7:0] TCR_LOAD = 8'h80;
    localparam logic [7:0] TCR_OFF  = 8'h00;
    localparam logic [7:0] TSR_CLR  = 8'h00;

    state_t           state_q, state_d;
    phase_t           ph_q, ph_d;
    logic [3:0]       gap_q;
    logic [7:0]       tdr_q;
    logic             updown_q;
    logic [1:0]       cks_q;
    logic             periodic_q;
    logic             stop_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic in_xfer, xfer_done, accept, stop_any, flag;

    function automatic logic is_xfer(input state_t s);
        return s inside {S_WR_TDR, S_WR_LOAD, S_WR_EN, S_RD_TSR, S_WR_CLR, S_WR_DIS};
    endfunction

    always_comb begin
        in_xfer   = is_xfer(state_q);
        xfer_done = in_xfer && (ph_q == PH_ACCESS) && apb.pready;
        accept    = ((state_q == S_IDLE) || (state_q == S_ERR)) && start && !stop;
        stop_any  = stop_q || stop;
        flag      = |(apb.prdata & (updown_q ? 8'h02 : 8'h01));
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_WR_TDR;
            S_ERR: begin
                if (stop)        state_d = S_IDLE;
                else if (accept) state_d = S_WR_TDR;
            end
            S_GAP: begin
                if (stop_any)           state_d = S_WR_DIS;
                else if (gap_q == '0)   state_d = S_RD_TSR;
            end
            S_EVT: state_d = (periodic_q && !stop_any) ? S_WR_TDR : S_WR_DIS;
            default: begin
                if (ph_q == PH_GAP) begin
                    ph_d = PH_SETUP;
                end else if (ph_q == PH_SETUP) begin
                    ph_d = PH_ACCESS;
                end else if (xfer_done) begin
                    if (apb.pslverr)               state_d = S_ERR;
                    else if (state_q == S_WR_DIS)  state_d = S_IDLE;
                    else if (state_q == S_WR_CLR)  state_d = S_EVT;
                    else if (stop_any)             state_d = S_WR_DIS;
                    else begin
                        case (state_q)
                            S_WR_TDR:  state_d = S_WR_LOAD;
                            S_WR_LOAD: state_d = S_WR_EN;
                            S_WR_EN:   state_d = S_GAP;
                            default:   state_d = flag ? S_WR_CLR : S_GAP;
                        endcase
                    end
                end
            end
        endcase
        // Back-to-back transfers need a psel-low cycle; after a non-transfer state psel is already low.
        if (state_d != state_q) ph_d = in_xfer ? PH_GAP : PH_SETUP;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            ph_q       <= PH_GAP;
            gap_q      <= '0;
            tdr_q      <= '0;
            updown_q   <= 1'b0;
            cks_q      <= '0;
            periodic_q <= 1'b0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;

            if ((state_d == S_GAP) && (state_q != S_GAP)) gap_q <= 4'(POLL_GAP - 1);
            else if (gap_q != '0)                          gap_q <= gap_q - 4'd1;

            if (accept) begin
                tdr_q      <= cfg_tdr;
                updown_q   <= cfg_updown;
                cks_q      <= cfg_cks;
                periodic_q <= cfg_periodic;
                err_q      <= 1'b0;
                cnt_q      <= '0;
            end else begin
                if (xfer_done && apb.pslverr) err_q <= 1'b1;
                if ((state_d == S_EVT) && (state_q != S_EVT) && (cnt_q != '1))
                    cnt_q <= cnt_q + CNT_W'(1);
            end

            if (accept || (state_d == S_IDLE)) stop_q <= 1'b0;
            else if (stop && busy)             stop_q <= 1'b1;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE) && (state_q != S_ERR);
        event_pulse = (state_q == S_EVT);
        event_cnt   = cnt_q;
        err         = err_q;

        apb.psel    = in_xfer && (ph_q != PH_GAP);
        apb.penable = in_xfer && (ph_q == PH_ACCESS);
        apb.pwrite  = in_xfer && (state_q != S_RD_TSR);
        apb.paddr   = '0;
        apb.pwdata  = '0;
        case (state_q)
            S_WR_TDR:  begin apb.paddr = ADDR_TDR; apb.pwdata = tdr_q;    end
            S_WR_LOAD: begin apb.paddr = ADDR_TCR; apb.pwdata = TCR_LOAD; end
            S_WR_EN: begin
                apb.paddr  = ADDR_TCR;
                apb.pwdata = {2'b00, updown_q, 1'b1, 2'b00, cks_q};
            end
            S_RD_TSR:  apb.paddr = ADDR_TSR;
            S_WR_CLR:  begin apb.paddr = ADDR_TSR; apb.pwdata = TSR_CLR;  end
            S_WR_DIS:  begin apb.paddr = ADDR_TCR; apb.pwdata = TCR_OFF;  end
            default: ;
        endcase
    end

endmodule
